ula_responder: RTL and testbench

Slave end of the ULA interface: it receives the operations a ULA master drives and returns one result per accepted request. It holds a bank of four 32-bit registers. Each request names an operation (`instru`), a target register (`reg_sel`) and a 16-bit operand (`A`). The block updates the selected register and returns its new value on `data_out` with a one-cycle `valid_out` pulse. A small request FIFO absorbs bursts, because the interface has no backpressure.

---
 rtl/ula_pkg.sv | 58 +++++
 rtl/ula_req_fifo.sv | 61 ++++++
 rtl/ula_responder.sv | 164 ++++++++++++++++
 tb/tb_ula_responder.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ula_pkg.sv
// ula_pkg -- shared types and helpers for the ULA responder slice.
//
// Contents:
//   DATA_W, A_W   register width (32) and operand width (16)
//   ula_op_e      opcode encoding carried on instru
//   ula_state_e   responder FSM states
//   ula_req_t     one queued request {instru, reg_sel, a}
//   alu_single    result of every opcode that completes in one EXEC cycle
//
// Build option: ULA_MUL_EN. When it is undefined, opcode 10 is an XOR
// handled by alu_single. When it is defined, opcode 10 goes through the
// iterative multiplier in the top level.
package ula_pkg;

  localparam int DATA_W = 32;
  localparam int A_W    = 16;

  typedef enum logic [1:0] {
    ULA_ADD  = 2'b00,
    ULA_SUB  = 2'b01,
    ULA_MUL  = 2'b10,
    ULA_LOAD = 2'b11
  } ula_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    MUL  = 2'd2
  } ula_state_e;

  typedef struct packed {
    ula_op_e          instru;
    logic [1:0]       reg_sel;
    logic [A_W-1:0]   a;
  } ula_req_t;

  // New register value for the opcodes that finish in one EXEC cycle.
  // The operand is always zero-extended; wrap-around is modulo 2^DATA_W.
  function automatic logic [DATA_W-1:0] alu_single(input ula_op_e op,
                                                    input logic [DATA_W-1:0] r,
                                                    input logic [A_W-1:0] a);
    logic [DATA_W-1:0] a_ext;
    a_ext = {{(DATA_W - A_W){1'b0}}, a};
    case (op)
      ULA_ADD:  return r + a_ext;
      ULA_SUB:  return r - a_ext;
      ULA_LOAD: return a_ext;
`ifdef ULA_MUL_EN
      // The multiplier state handles this opcode; EXEC never sees it.
      ULA_MUL:  return r;
`else
      ULA_MUL:  return r ^ a_ext;
`endif
      default:  return r;
    endcase
  endfunction

endpackage

// File: rtl/ula_req_fifo.sv
// ula_req_fifo -- synchronous FIFO of ula_req_t requests.
//
// Parameters:
//   FIFO_DEPTH  number of entries, power of two and at least 2
// Ports:
//   clk, rst_n  clock and asynchronous active-low reset (FIFO empties)
//   push        write din this edge; the caller only pushes when there is room
//               (not full, or a pop on the same edge)
//   pop         drop the head entry this edge; the caller only pops when non-empty
//   din         request to write
//   full/empty  occupancy flags
//   head        oldest entry (combinational read)
//
// Pointers carry one extra bit so full and empty are told apart when the
// index bits match.
module ula_req_fifo
  import ula_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
) (
  input  logic     clk,
  input  logic     rst_n,
  input  logic     push,
  input  logic     pop,
  input  ula_req_t din,
  output logic     full,
  output logic     empty,
  output ula_req_t head
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam logic [PTR_W:0] PTR_ONE = {{PTR_W{1'b0}}, 1'b1};

  ula_req_t       mem [FIFO_DEPTH];
  logic [PTR_W:0] wr_ptr;
  logic [PTR_W:0] rd_ptr;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                 (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
  assign head  = mem[rd_ptr[PTR_W-1:0]];

  // NOTE: sequential state uses non-blocking (<=) so every flop samples
  // pre-edge values regardless of process ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

  // NOTE: the storage array is deliberately not reset. The pointers alone
  // define which entries are valid, and a reset-free array maps to plain RAM.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[PTR_W-1:0]] <= din;
  end

endmodule

// File: rtl/ula_responder.sv
// ula_responder -- slave end of the ULA interface.
//
// Queues requests in a FIFO. It executes them in order against four 32-bit
// registers and returns each new register value with a one-cycle strobe.
//
// Parameters:
//   FIFO_DEPTH  request FIFO entries (power of two, >= 2)
// Ports:
//   clk_ula     clock, rising edge
//   rst         asynchronous active-low reset; aborts all work in flight
//   A           16-bit operand
//   reg_sel     target register R0..R3
//   instru      opcode (ula_op_e)
//   valid_ula   request qualifier, sampled every edge
//   data_out    new value of the target register, held between strobes
//   valid_out   one-cycle result strobe
//
// Build option: ULA_MUL_EN enables the 16-step shift-add multiplier for
// opcode 10. Without it, opcode 10 is a single-cycle XOR.
module ula_responder
  import ula_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk_ula,
  input  logic              rst,
  input  logic [A_W-1:0]    A,
  input  logic [1:0]        reg_sel,
  input  logic [1:0]        instru,
  input  logic              valid_ula,
  output logic [DATA_W-1:0] data_out,
  output logic              valid_out
);

  ula_state_e        state, state_next;
  logic [DATA_W-1:0] regs [4];

  ula_op_e           cur_op;
  logic [1:0]        cur_sel;
  logic [A_W-1:0]    cur_a;
  logic [DATA_W-1:0] exec_result;

  ula_req_t          req_in;
  ula_req_t          head;
  logic              fifo_full;
  logic              fifo_empty;
  logic              pop;
  logic              push;

`ifdef ULA_MUL_EN
  logic [3:0]        cnt;
  logic [DATA_W-1:0] acc;
  logic [DATA_W-1:0] mcand;
  logic [A_W-1:0]    mplier;
  logic [DATA_W-1:0] acc_next;
`endif

  assign req_in = {ula_op_e'(instru), reg_sel, A};
  // No backpressure exists: a request that finds the FIFO full is dropped.
  // A pop on the same edge frees a slot.
  assign push   = valid_ula && (!fifo_full || pop);

  ula_req_fifo #(
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk_ula),
    .rst_n (rst),
    .push  (push),
    .pop   (pop),
    .din   (req_in),
    .full  (fifo_full),
    .empty (fifo_empty),
    .head  (head)
  );

  // Registers are read in EXEC, after the previous request's write has
  // landed. Dependent requests therefore see earlier results.
  assign exec_result = alu_single(cur_op, regs[cur_sel], cur_a);

`ifdef ULA_MUL_EN
  // One shift-add step: mcand walks left while mplier walks right.
  assign acc_next = acc + (mplier[0] ? mcand : '0);
`endif

  // NOTE: every output of this block gets a default first, so no path
  // leaves a value unassigned and no latch is inferred.
  always_comb begin
    state_next = state;
    pop        = 1'b0;
    case (state)
      IDLE: begin
        if (!fifo_empty) begin
          pop = 1'b1;
`ifdef ULA_MUL_EN
          state_next = (head.instru == ULA_MUL) ? MUL : EXEC;
`else
          state_next = EXEC;
`endif
        end
      end
      EXEC: state_next = IDLE;
`ifdef ULA_MUL_EN
      MUL:  if (cnt == 4'd15) state_next = IDLE;
`endif
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_ula or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      for (int i = 0; i < 4; i++) regs[i] <= '0;
      cur_op    <= ULA_ADD;
      cur_sel   <= '0;
      cur_a     <= '0;
      data_out  <= '0;
      valid_out <= 1'b0;
`ifdef ULA_MUL_EN
      cnt       <= '0;
      acc       <= '0;
      mcand     <= '0;
      mplier    <= '0;
`endif
    end else begin
      state     <= state_next;
      valid_out <= 1'b0;
      case (state)
        IDLE: begin
          if (pop) begin
            cur_op  <= head.instru;
            cur_sel <= head.reg_sel;
            cur_a   <= head.a;
`ifdef ULA_MUL_EN
            cnt     <= '0;
            acc     <= '0;
            mcand   <= {{(DATA_W - A_W){1'b0}}, regs[head.reg_sel][A_W-1:0]};
            mplier  <= head.a;
`endif
          end
        end
        EXEC: begin
          regs[cur_sel] <= exec_result;
          data_out      <= exec_result;
          valid_out     <= 1'b1;
        end
`ifdef ULA_MUL_EN
        MUL: begin
          acc    <= acc_next;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          cnt    <= cnt + 4'd1;
          if (cnt == 4'd15) begin
            regs[cur_sel] <= acc_next;
            data_out      <= acc_next;
            valid_out     <= 1'b1;
          end
        end
`endif
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ula_responder.sv
// tb_ula_responder -- scoreboard bench for ula_responder.
//
// A transaction-level reference model runs on each rising edge. It keeps a
// request queue, the four register values and the cycle at which the server
// next becomes free. Its expected result and completion cycle go into a
// scoreboard queue. A monitor on the falling edge pops that queue whenever
// valid_out is seen. Directed checks from the test plan are followed by
// random traffic. Honours ULA_MUL_EN the same way the design does.
module tb_ula_responder;
  import ula_pkg::*;

  localparam int DEPTH = 4;

  logic        clk_ula = 1'b0;
  logic        rst = 1'b0;
  logic [15:0] A = '0;
  logic [1:0]  reg_sel = '0;
  logic [1:0]  instru = '0;
  logic        valid_ula = 1'b0;
  logic [31:0] data_out;
  logic        valid_out;

  ula_responder #(.FIFO_DEPTH(DEPTH)) dut (
    .clk_ula   (clk_ula),
    .rst       (rst),
    .A         (A),
    .reg_sel   (reg_sel),
    .instru    (instru),
    .valid_ula (valid_ula),
    .data_out  (data_out),
    .valid_out (valid_out)
  );

  always #5 clk_ula = ~clk_ula;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int pulses = 0;
  bit prev_valid = 1'b0;

  typedef struct { bit [1:0] op; bit [1:0] sel; bit [15:0] a; } m_req_t;
  typedef struct { bit [31:0] data; int due; } exp_t;

  m_req_t    mq[$];
  exp_t      sb[$];
  bit [31:0] mregs [4];
  int        next_free = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Opcode semantics as plain arithmetic on 32-bit values.
  function automatic bit [31:0] ref_op(input bit [1:0] op, input bit [31:0] r, input bit [15:0] a);
    case (op)
      2'b00: return r + 32'(a);
      2'b01: return r - 32'(a);
`ifdef ULA_MUL_EN
      2'b10: return 32'(r[15:0]) * 32'(a);
`else
      2'b10: return r ^ 32'(a);
`endif
      default: return 32'(a);
    endcase
  endfunction

  function automatic bit is_iterative(input bit [1:0] op);
`ifdef ULA_MUL_EN
    return op == 2'b10;
`else
    return 1'b0;
`endif
  endfunction

  // Reference model. A request is served once the server is free and the
  // queue is non-empty. A single-cycle op finishes on the next edge and
  // frees the server one edge later. A multiply finishes 16 edges later.
  always @(posedge clk_ula or negedge rst) begin
    if (!rst) begin
      mq.delete();
      sb.delete();
      for (int i = 0; i < 4; i++) mregs[i] = '0;
      next_free = 0;
    end else begin
      bit     served;
      m_req_t r;
      bit [31:0] res;
      cyc++;
      served = (cyc >= next_free) && (mq.size() > 0);
      if (served) begin
        r = mq.pop_front();
        res = ref_op(r.op, mregs[r.sel], r.a);
        mregs[r.sel] = res;
        sb.push_back('{res, cyc + (is_iterative(r.op) ? 16 : 1)});
        next_free = cyc + (is_iterative(r.op) ? 17 : 2);
      end
      if (valid_ula && mq.size() < DEPTH)
        mq.push_back('{instru, reg_sel, A});
    end
  end

  // Monitor: pairs each strobe with the oldest expected result.
  always @(negedge clk_ula) begin
    if (!rst) begin
      prev_valid = 1'b0;
    end else begin
      if (valid_out) begin
        exp_t e;
        pulses++;
        check("valid_gap", {31'b0, prev_valid}, 32'd0);
        if (sb.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_valid: data_out %h with no result pending (cycle %0d)", data_out, cyc);
        end else begin
          e = sb.pop_front();
          check("sb_data", data_out, e.data);
          check("sb_cycle", cyc, e.due);
        end
      end
      prev_valid = valid_out;
    end
  end

  // Present one request for one edge; call and return on a falling edge.
  task automatic req(input bit [1:0] op, input bit [1:0] sel, input bit [15:0] a);
    instru    = op;
    reg_sel   = sel;
    A         = a;
    valid_ula = 1'b1;
    @(negedge clk_ula);
    valid_ula = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk_ula);
  endtask

  // Issue a single-cycle request on an idle block and check its result.
  task automatic single(input string name, input bit [1:0] op, input bit [1:0] sel,
                        input bit [15:0] a, input bit [31:0] exp);
    req(op, sel, a);
    idle(1);
    check({name, "_early"}, {31'b0, valid_out}, 32'd0);
    idle(1);
    check({name, "_valid"}, {31'b0, valid_out}, 32'd1);
    check({name, "_data"}, data_out, exp);
  endtask

  initial begin
    int p0;

    // Reset state
    idle(3);
    check("rst_valid_out", {31'b0, valid_out}, 32'd0);
    check("rst_data_out", data_out, 32'd0);
    rst = 1'b1;
    idle(2);

    // LOAD R1, others untouched
    single("load_r1", ULA_LOAD, 2'd1, 16'h1234, 32'h0000_1234);
    idle(1);
    check("data_hold", data_out, 32'h0000_1234);
    single("r0_zero", ULA_ADD, 2'd0, 16'h0, 32'h0);
    single("r2_zero", ULA_ADD, 2'd2, 16'h0, 32'h0);
    single("r3_zero", ULA_ADD, 2'd3, 16'h0, 32'h0);

    // Wrap-around both ways
    single("sub_wrap", ULA_SUB, 2'd0, 16'h0001, 32'hFFFF_FFFF);
    single("add_wrap", ULA_ADD, 2'd0, 16'h0002, 32'h0000_0001);

`ifdef ULA_MUL_EN
    // Largest product, 17-cycle latency
    single("load_r2", ULA_LOAD, 2'd2, 16'hFFFF, 32'h0000_FFFF);
    req(ULA_MUL, 2'd2, 16'hFFFF);
    idle(16);
    check("mul_early", {31'b0, valid_out}, 32'd0);
    idle(1);
    check("mul_valid", {31'b0, valid_out}, 32'd1);
    check("mul_data", data_out, 32'hFFFE_0001);
    idle(2);

    // LOADs arriving behind a multiply: two of six are dropped
    p0 = pulses;
    req(ULA_MUL, 2'd0, 16'h0003);
    idle(1);
    for (int i = 1; i <= 6; i++) req(ULA_LOAD, 2'd3, 16'(i));
    idle(30);
    check("burst_pulses", pulses - p0, 32'd5);
    check("burst_last", data_out, 32'h0000_0004);
`else
    // Opcode 10 as XOR
    single("load_r1_f0", ULA_LOAD, 2'd1, 16'h00F0, 32'h0000_00F0);
    single("xor_r1", ULA_MUL, 2'd1, 16'h0FF0, 32'h0000_0F00);
    idle(2);
`endif

    // A continuous stream of 12 LOADs: 10 accepted, requests 8 and 10 dropped
    p0 = pulses;
    for (int i = 0; i < 12; i++) req(ULA_LOAD, 2'(i), 16'(16'h100 + i));
    idle(30);
    check("stream_pulses", pulses - p0, 32'd10);
    check("stream_last", data_out, 32'h0000_010B);

    // Reset during work in flight: nothing completes, everything clears
    single("load_r1_7", ULA_LOAD, 2'd1, 16'h0007, 32'h0000_0007);
    req(ULA_MUL, 2'd1, 16'h0005);
    req(ULA_LOAD, 2'd2, 16'h0009);
    req(ULA_LOAD, 2'd3, 16'h000A);
    idle(6);
    rst = 1'b0;
    idle(2);
    check("rst_mid_valid", {31'b0, valid_out}, 32'd0);
    check("rst_mid_data", data_out, 32'd0);
    rst = 1'b1;
    idle(20);
    for (int i = 0; i < 4; i++) single($sformatf("post_rst_r%0d", i), ULA_ADD, 2'(i), 16'h0, 32'h0);
    single("post_rst_load", ULA_LOAD, 2'd0, 16'h00AA, 32'h0000_00AA);

    // Random traffic against the model
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 1) == 1) begin
        bit [1:0]  op;
        bit [15:0] a;
        op = 2'($urandom_range(0, 3));
        a  = ($urandom_range(0, 3) == 0) ? 16'hFFFF : 16'($urandom);
        req(op, 2'($urandom_range(0, 3)), a);
      end else begin
        idle(1);
      end
    end

    // Drain, bounded
    for (int i = 0; i < 2000 && sb.size() > 0; i++) idle(1);
    idle(3);
    check("sb_drained", sb.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
